// File: rtl/brick_grid_pkg.sv
// brick_grid_pkg: shared command codes, FSM state encoding and row popcount helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package brick_grid_pkg;

  // Command function codes carried on cmd_func
  localparam logic [2:0] FN_CLEAR = 3'b000;
  localparam logic [2:0] FN_LOAD  = 3'b001;
  localparam logic [2:0] FN_DROP  = 3'b010;
  localparam logic [2:0] FN_PULL  = 3'b011;
  localparam logic [2:0] FN_HIT   = 3'b100;

  typedef enum logic [1:0] {
    ST_SWEEP = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Widest row the popcount helper accepts; callers zero-extend into it.
  localparam int MAX_ROW_BITS = 1024;
  localparam int MAX_COLS     = 256;

  // Number of non-empty cells in a packed row of `cols` cells, `cell_w` bits each.
  function automatic int unsigned row_popcount(input logic [MAX_ROW_BITS-1:0] row,
                                               input int cols, input int cell_w);
    int unsigned             cnt;
    logic [MAX_ROW_BITS-1:0] one;
    logic [MAX_ROW_BITS-1:0] mask;
    cnt    = 0;
    one    = '0;
    one[0] = 1'b1;
    mask   = (one << cell_w) - one;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (c < cols) begin
        if (((row >> (c * cell_w)) & mask) != '0) cnt++;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/brick_grid_row_mem.sv
// brick_grid_row_mem: ROWS x (COLS*CELL_W) register array for the brick field.
// Latency: cell and row ports read combinationally, write at the clock edge; rd port is registered (1 cycle).
// Backpressure: none; the owner sequences all accesses.
// Ports: clock/reset; cell_* = one read-modify-write cell port; row_* = full-row read/write port
//        used by the sweep and shifts; rd_* = registered cell read (read-before-write), 0 when disabled.
module brick_grid_row_mem
  import brick_grid_pkg::*;
#(
  parameter int ROWS   = 24,
  parameter int COLS   = 32,
  parameter int CELL_W = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cell_we_i,
  input  logic [$clog2(ROWS)-1:0]   cell_row_i,
  input  logic [$clog2(COLS)-1:0]   cell_col_i,
  input  logic [CELL_W-1:0]         cell_wdata_i,
  output logic [CELL_W-1:0]         cell_rdata_o,
  input  logic                      row_we_i,
  input  logic [$clog2(ROWS)-1:0]   row_waddr_i,
  input  logic [COLS*CELL_W-1:0]    row_wdata_i,
  input  logic [$clog2(ROWS)-1:0]   row_raddr_i,
  output logic [COLS*CELL_W-1:0]    row_rdata_o,
  input  logic                      rd_en_i,
  input  logic [$clog2(ROWS)-1:0]   rd_row_i,
  input  logic [$clog2(COLS)-1:0]   rd_col_i,
  output logic [CELL_W-1:0]         rd_data_o
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW:0] ROWS_LIM = (RW+1)'(ROWS);
  localparam logic [CW:0] COLS_LIM = (CW+1)'(COLS);

  logic [COLS*CELL_W-1:0] mem_q [ROWS];
  logic [CELL_W-1:0]      rd_q;

  // Extended compare keeps the test meaningful for non-power-of-2 dimensions.
  function automatic logic row_ok(input logic [RW-1:0] r);
    return {1'b0, r} < ROWS_LIM;
  endfunction

  function automatic logic col_ok(input logic [CW-1:0] c);
    return {1'b0, c} < COLS_LIM;
  endfunction

  assign cell_rdata_o = (row_ok(cell_row_i) && col_ok(cell_col_i))
                      ? mem_q[cell_row_i][cell_col_i*CELL_W +: CELL_W] : '0;
  assign row_rdata_o  = row_ok(row_raddr_i) ? mem_q[row_raddr_i] : '0;
  assign rd_data_o    = rd_q;

  // Row and cell writes are never enabled in the same cycle by the owner.
  always_ff @(posedge clock) begin
    if (row_we_i && row_ok(row_waddr_i))
      mem_q[row_waddr_i] <= row_wdata_i;
    if (cell_we_i && row_ok(cell_row_i) && col_ok(cell_col_i))
      mem_q[cell_row_i][cell_col_i*CELL_W +: CELL_W] <= cell_wdata_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en_i && row_ok(rd_row_i) && col_ok(rd_col_i)) begin
      rd_q <= mem_q[rd_row_i][rd_col_i*CELL_W +: CELL_W];
    end else begin
      rd_q <= '0;
    end
  end

endmodule

// File: rtl/brick_grid.sv
// brick_grid: Arkanoid brick-field store with command port (CLEAR/LOAD/HIT/DROP/PULL) and cell read port.
// Latency: CLEAR/LOAD/HIT/NOP done 1 cycle after accept; DROP/PULL done ROWS+1 cycles after accept; read 1 cycle.
// Backpressure: cmd_ready = !busy (reset sweep or shift); commands offered while busy are not queued.
// Ports: clock, reset (sync, active-high); cmd_valid/cmd_ready/cmd_func/cmd_row/cmd_col/cmd_data command in;
//        cmd_done/hit_old completion out; busy; rd_row/rd_col -> rd_data; bricks_left.
// Option: define BRICK_GRID_COUNT_EN to maintain bricks_left; otherwise it is tied to 0.
module brick_grid
  import brick_grid_pkg::*;
#(
  parameter int ROWS   = 24,
  parameter int COLS   = 32,
  parameter int CELL_W = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [2:0]                        cmd_func,
  input  logic [$clog2(ROWS)-1:0]           cmd_row,
  input  logic [$clog2(COLS)-1:0]           cmd_col,
  input  logic [CELL_W-1:0]                 cmd_data,
  output logic                              cmd_done,
  output logic [CELL_W-1:0]                 hit_old,
  output logic                              busy,
  input  logic [$clog2(ROWS)-1:0]           rd_row,
  input  logic [$clog2(COLS)-1:0]           rd_col,
  output logic [CELL_W-1:0]                 rd_data,
  output logic [$clog2(ROWS*COLS+1)-1:0]    bricks_left
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CNT_W = $clog2(ROWS*COLS+1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);
  localparam logic [RW:0]   ROWS_LIM = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_LIM = (CW+1)'(COLS);

  state_t            state_q;
  logic [RW-1:0]     ptr_q;
  logic              pull_q;
  logic              done_q;
  logic [CELL_W-1:0] hit_old_q;

  logic                   cmd_acc;
  logic                   cmd_in_range;
  logic                   is_shift;
  logic                   shift_acc;
  logic                   shift_last;
  logic [RW-1:0]          shift_end;
  logic                   cell_we;
  logic [CELL_W-1:0]      cell_old;
  logic [CELL_W-1:0]      cell_new;
  logic                   row_we;
  logic [RW-1:0]          row_raddr;
  logic [COLS*CELL_W-1:0] row_rdata;
  logic [COLS*CELL_W-1:0] row_wdata;

  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = !busy;
  assign cmd_done  = done_q;
  assign hit_old   = hit_old_q;

  assign cmd_acc      = cmd_valid && cmd_ready && !reset;
  assign cmd_in_range = ({1'b0, cmd_row} < ROWS_LIM) && ({1'b0, cmd_col} < COLS_LIM);
  assign is_shift     = (cmd_func == FN_DROP) || (cmd_func == FN_PULL);
  assign shift_acc    = cmd_acc && is_shift;
  assign shift_end    = pull_q ? ROW_LAST : '0;
  assign shift_last   = !reset && (state_q == ST_SHIFT) && (ptr_q == shift_end);

  assign cell_we = cmd_acc && cmd_in_range &&
                   ((cmd_func == FN_CLEAR) || (cmd_func == FN_LOAD) || (cmd_func == FN_HIT));

  always_comb begin
    cell_new = '0;
    case (cmd_func)
      FN_LOAD: cell_new = cmd_data;
      FN_HIT:  cell_new = (cell_old == '0) ? '0 : cell_old - 1'b1;
      default: cell_new = '0;
    endcase
  end

  // Sweep zeroes row ptr_q; a shift copies the neighbour row in, and the edge row
  // at the end of the walk (row 0 for DROP, ROWS-1 for PULL) is filled with zeros.
  assign row_we    = !reset && ((state_q == ST_SWEEP) || (state_q == ST_SHIFT));
  assign row_wdata = ((state_q == ST_SHIFT) && (ptr_q != shift_end)) ? row_rdata : '0;

  // In IDLE the row port looks at the row a DROP/PULL would discard, for the counter.
  always_comb begin
    row_raddr = pull_q ? ptr_q + 1'b1 : ptr_q - 1'b1;
    if (state_q != ST_SHIFT)
      row_raddr = (cmd_func == FN_PULL) ? '0 : ROW_LAST;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_SWEEP;
      ptr_q     <= '0;
      pull_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_old_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_SWEEP: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == ROW_LAST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
          end
        end
        ST_IDLE: begin
          if (shift_acc) begin
            state_q <= ST_SHIFT;
            pull_q  <= (cmd_func == FN_PULL);
            ptr_q   <= (cmd_func == FN_PULL) ? '0 : ROW_LAST;
          end else if (cmd_acc) begin
            done_q <= 1'b1;
            if (cmd_func == FN_HIT)
              hit_old_q <= cmd_in_range ? cell_old : '0;
          end
        end
        ST_SHIFT: begin
          if (shift_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= pull_q ? ptr_q + 1'b1 : ptr_q - 1'b1;
          end
        end
        default: state_q <= ST_SWEEP;
      endcase
    end
  end

  brick_grid_row_mem #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CELL_W (CELL_W)
  ) u_mem (
    .clock        (clock),
    .reset        (reset),
    .cell_we_i    (cell_we),
    .cell_row_i   (cmd_row),
    .cell_col_i   (cmd_col),
    .cell_wdata_i (cell_new),
    .cell_rdata_o (cell_old),
    .row_we_i     (row_we),
    .row_waddr_i  (ptr_q),
    .row_wdata_i  (row_wdata),
    .row_raddr_i  (row_raddr),
    .row_rdata_o  (row_rdata),
    .rd_en_i      (!busy),
    .rd_row_i     (rd_row),
    .rd_col_i     (rd_col),
    .rd_data_o    (rd_data)
  );

`ifdef BRICK_GRID_COUNT_EN
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] disc_q;

  // The discarded row is counted at accept time and subtracted when the shift
  // completes, so the new total appears together with cmd_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      disc_q  <= '0;
    end else begin
      if (cell_we) begin
        if ((cell_old == '0) && (cell_new != '0))
          count_q <= count_q + 1'b1;
        else if ((cell_old != '0) && (cell_new == '0))
          count_q <= count_q - 1'b1;
      end
      if (shift_acc)
        disc_q <= CNT_W'(row_popcount(MAX_ROW_BITS'(row_rdata), COLS, CELL_W));
      if (shift_last)
        count_q <= count_q - disc_q;
    end
  end

  assign bricks_left = count_q;
`else
  assign bricks_left = '0;
`endif

endmodule

// File: tb/tb_brick_grid.sv
// tb_brick_grid: directed self-checking bench for brick_grid at ROWS=24, COLS=32, CELL_W=3.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: commands wait (bounded) for cmd_ready before being offered.
module tb_brick_grid;
  import brick_grid_pkg::*;

  localparam int ROWS   = 24;
  localparam int COLS   = 32;
  localparam int CELL_W = 3;
  localparam int RW     = 5;
  localparam int CW     = 5;
  localparam int CNT_W  = 10;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_func;
  logic [RW-1:0]     cmd_row;
  logic [CW-1:0]     cmd_col;
  logic [CELL_W-1:0] cmd_data;
  logic              cmd_done;
  logic [CELL_W-1:0] hit_old;
  logic              busy;
  logic [RW-1:0]     rd_row;
  logic [CW-1:0]     rd_col;
  logic [CELL_W-1:0] rd_data;
  logic [CNT_W-1:0]  bricks_left;

  int n_checks;
  int n_errors;

  brick_grid #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_func    (cmd_func),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .cmd_data    (cmd_data),
    .cmd_done    (cmd_done),
    .hit_old     (hit_old),
    .busy        (busy),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .bricks_left (bricks_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  // Expected brick count: the counter only exists when the option is compiled in.
  function automatic int bl(input int n);
`ifdef BRICK_GRID_COUNT_EN
    return n;
`else
    return n & 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_cell(input int r, input int c, output int v);
    rd_row = RW'(r);
    rd_col = CW'(c);
    tick();
    v = int'(rd_data);
  endtask

  task automatic count_nz(input int r0, input int r1, output int n);
    int v;
    n = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, v);
        if (v != 0) n++;
      end
  endtask

  // Offers one command and returns at the sample point of the cycle after acceptance.
  task automatic issue(input logic [2:0] f, input int r, input int c, input int d);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      tick();
      w++;
    end
    check("ready_wait", 32'(w < 100), 1);
    cmd_valid = 1'b1;
    cmd_func  = f;
    cmd_row   = RW'(r);
    cmd_col   = CW'(c);
    cmd_data  = CELL_W'(d);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Counts busy cycles from the current sample point and any premature done pulses.
  task automatic wait_busy(input logic chk_rd, output int cycles, output int early_done);
    cycles     = 0;
    early_done = 0;
    while (busy && cycles < 100) begin
      if (cmd_done) early_done++;
      if (chk_rd && cycles == 5) check("rd_while_busy", 32'(rd_data), 0);
      tick();
      cycles++;
    end
  endtask

  initial begin
    int v, n, dn;
    int exp_old [4];
    int exp_cnt [4];
    exp_old = '{3, 2, 1, 0};
    exp_cnt = '{1, 1, 0, 0};
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_func  = 3'b111;
    cmd_row   = '0;
    cmd_col   = '0;
    cmd_data  = '0;
    rd_row    = 5'd3;
    rd_col    = 5'd3;

    // 1. reset and sweep
    tick();
    check("rst_busy", 32'(busy), 1);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_done", 32'(cmd_done), 0);
    check("rst_hit_old", 32'(hit_old), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_bricks", 32'(bricks_left), 0);
    reset = 1'b0;
    wait_busy(1'b0, n, dn);
    check("sweep_cycles", 32'(n), 24);
    check("sweep_no_done", 32'(dn + int'(cmd_done)), 0);
    check("sweep_rd", 32'(rd_data), 0);
    check("sweep_bricks", 32'(bricks_left), 0);
    count_nz(0, ROWS-1, n);
    check("sweep_grid_zero", 32'(n), 0);

    // 2. LOAD then HIT x4
    issue(FN_LOAD, 5, 7, 3);
    check("load_done", 32'(cmd_done), 1);
    check("load_ready", 32'(cmd_ready), 1);
    check("load_bricks", 32'(bricks_left), 32'(bl(1)));
    for (int i = 0; i < 4; i++) begin
      issue(FN_HIT, 5, 7, 0);
      check("hit_done", 32'(cmd_done), 1);
      check("hit_old", 32'(hit_old), 32'(exp_old[i]));
      check("hit_bricks", 32'(bricks_left), 32'(bl(exp_cnt[i])));
    end
    read_cell(5, 7, v);
    check("hit_final_cell", 32'(v), 0);

    // 3. DROP
    issue(FN_LOAD, 23, 0, 2);
    issue(FN_LOAD, 0, 31, 4);
    check("pre_drop_bricks", 32'(bricks_left), 32'(bl(2)));
    rd_row = 5'd0;
    rd_col = 5'd31;
    issue(FN_DROP, 0, 0, 0);
    check("drop_busy", 32'(busy), 1);
    check("drop_no_done_t1", 32'(cmd_done), 0);
    wait_busy(1'b1, n, dn);
    check("drop_cycles", 32'(n), 24);
    check("drop_early_done", 32'(dn), 0);
    check("drop_done", 32'(cmd_done), 1);
    check("drop_bricks", 32'(bricks_left), 32'(bl(1)));
    tick();
    check("drop_done_pulse", 32'(cmd_done), 0);
    read_cell(1, 31, v);
    check("drop_moved", 32'(v), 4);
    read_cell(23, 0, v);
    check("drop_discard", 32'(v), 0);
    count_nz(0, 0, n);
    check("drop_row0_zero", 32'(n), 0);
    count_nz(0, ROWS-1, n);
    check("drop_grid_nz", 32'(n), 1);
    issue(FN_CLEAR, 1, 31, 0);
    check("clear_bricks", 32'(bricks_left), 32'(bl(0)));

    // 4. PULL
    issue(FN_LOAD, 23, 0, 2);
    issue(FN_LOAD, 0, 31, 4);
    issue(FN_PULL, 0, 0, 0);
    wait_busy(1'b0, n, dn);
    check("pull_cycles", 32'(n), 24);
    check("pull_early_done", 32'(dn), 0);
    check("pull_done", 32'(cmd_done), 1);
    check("pull_bricks", 32'(bricks_left), 32'(bl(1)));
    read_cell(0, 31, v);
    check("pull_discard", 32'(v), 0);
    read_cell(22, 0, v);
    check("pull_moved", 32'(v), 2);
    count_nz(ROWS-1, ROWS-1, n);
    check("pull_row23_zero", 32'(n), 0);
    issue(FN_CLEAR, 22, 0, 0);

    // 5. read-before-write, out-of-range, NOP, back-to-back
    cmd_valid = 1'b1;
    cmd_func  = FN_LOAD;
    cmd_row   = 5'd2;
    cmd_col   = 5'd2;
    cmd_data  = 3'd6;
    rd_row    = 5'd2;
    rd_col    = 5'd2;
    tick();
    cmd_valid = 1'b0;
    check("rbw_old", 32'(rd_data), 0);
    check("rbw_done", 32'(cmd_done), 1);
    tick();
    check("rbw_new", 32'(rd_data), 6);
    issue(FN_HIT, 2, 2, 0);
    check("hit6_old", 32'(hit_old), 6);
    read_cell(2, 2, v);
    check("hit6_cell", 32'(v), 5);
    issue(FN_HIT, 30, 0, 0);
    check("oor_hit_done", 32'(cmd_done), 1);
    check("oor_hit_old", 32'(hit_old), 0);
    issue(FN_LOAD, 26, 0, 7);
    check("oor_load_done", 32'(cmd_done), 1);
    check("oor_load_bricks", 32'(bricks_left), 32'(bl(1)));
    issue(3'b111, 0, 0, 0);
    check("nop_done", 32'(cmd_done), 1);
    cmd_valid = 1'b1;
    cmd_func  = FN_LOAD;
    cmd_row   = 5'd3;
    cmd_col   = 5'd3;
    cmd_data  = 3'd1;
    tick();
    check("b2b_done1", 32'(cmd_done), 1);
    cmd_col  = 5'd4;
    cmd_data = 3'd2;
    tick();
    cmd_valid = 1'b0;
    check("b2b_done2", 32'(cmd_done), 1);
    check("b2b_bricks", 32'(bricks_left), 32'(bl(3)));
    read_cell(3, 4, v);
    check("b2b_cell", 32'(v), 2);

    // 6. reset in the middle of a DROP
    issue(FN_DROP, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_done", 32'(cmd_done), 0);
    check("abort_busy", 32'(busy), 1);
    wait_busy(1'b0, n, dn);
    check("abort_sweep_cycles", 32'(n), 24);
    check("abort_no_done", 32'(dn + int'(cmd_done)), 0);
    count_nz(0, ROWS-1, n);
    check("abort_grid_zero", 32'(n), 0);
    check("abort_bricks", 32'(bricks_left), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
